sram_arbiter: RTL and testbench

//  Shares the single-port sram controller between three requesters: video fetch, CPU (wishbone side) and
//  mem_copy loader. Sits between sram_wb-level logic and the sram rd/we/addr/din/dout pins, on clk_ram.

---
 rtl/sram_arbiter_pkg.sv | 22 ++
 rtl/sram_arbiter_pick.sv | 23 ++
 rtl/sram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and default timing for the sram arbiter.
// Owner encoding doubles as the value driven on the owner port.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_COPY = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RELEASE,
        ST_DONE
    } state_t;

    localparam int SLOT_CYC_DEF = 24;
    localparam int GAP_CYC_DEF  = 3;

endpackage

// File: rtl/sram_arbiter_pick.sv
// Fixed-priority winner select: video, then cpu, then copy.
// cp_first lets a starved copy request jump ahead of the cpu.
module sram_arbiter_pick
    import sram_arbiter_pkg::*;
(
    input  logic   vid_req,
    input  logic   cpu_req,
    input  logic   cp_req,
    input  logic   cp_first,
    output owner_t winner
);

    always_comb begin
        winner = OWN_NONE;
        if (vid_req)
            winner = OWN_VID;
        else if (cpu_req && !(cp_req && cp_first))
            winner = OWN_CPU;
        else if (cp_req)
            winner = OWN_COPY;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Time-sliced arbiter sharing one single-port sram between video, cpu and copy.
// The sram never acks, so every access runs a fixed slot plus a low gap.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW       = 24,
    parameter int SLOT_CYC = SLOT_CYC_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF,
    parameter int CPU_MAX  = 4
) (
    input  logic          clk_ram,
    input  logic          init,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_din,
    input  logic [1:0]    cpu_sel,
    input  logic          cp_req,
    input  logic          cp_we,
    input  logic [AW-1:0] cp_addr,
    input  logic [15:0]   cp_din,
    output logic          vid_ack,
    output logic          cpu_ack,
    output logic          cp_ack,
    output logic [15:0]   rdata,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_din,
    output logic [1:0]    ram_wtbt,
    output logic          ram_we,
    output logic          ram_rd,
    input  logic [15:0]   ram_dout,
    output logic [1:0]    owner
);

    localparam int FW = $clog2(CPU_MAX + 1);
    localparam logic [4:0]    SLOT_LAST = 5'(SLOT_CYC - 1);
    localparam logic [4:0]    GAP_LAST  = 5'(GAP_CYC - 1);
    localparam logic [FW-1:0] FAIR_MAX  = FW'(CPU_MAX);

    state_t        state, state_nx;
    owner_t        own, winner;
    logic [4:0]    cnt;
    logic [FW-1:0] fair;
    logic          wr;
    logic          grant, slot_end, gap_end;
    logic [AW-1:0] sel_addr;
    logic [15:0]   sel_din;
    logic [1:0]    sel_wtbt;
    logic          sel_we;

    sram_arbiter_pick u_pick (
        .vid_req  (vid_req),
        .cpu_req  (cpu_req),
        .cp_req   (cp_req),
        .cp_first (fair == FAIR_MAX),
        .winner   (winner)
    );

    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        sel_wtbt = 2'b11;
        sel_we   = 1'b0;
        case (winner)
            OWN_VID: sel_addr = vid_addr;
            OWN_CPU: begin
                sel_addr = cpu_addr;
                sel_din  = cpu_din;
                sel_we   = cpu_we;
                sel_wtbt = cpu_we ? cpu_sel : 2'b11;
            end
            OWN_COPY: begin
                sel_addr = cp_addr;
                sel_din  = cp_din;
                sel_we   = cp_we;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        slot_end = 1'b0;
        gap_end  = 1'b0;
        case (state)
            ST_IDLE:
                if (winner != OWN_NONE) begin
                    grant    = 1'b1;
                    state_nx = ST_ISSUE;
                end
            ST_ISSUE:
                if (cnt == SLOT_LAST) begin
                    slot_end = 1'b1;
                    state_nx = ST_RELEASE;
                end
            ST_RELEASE:
                if (cnt == GAP_LAST) begin
                    gap_end  = 1'b1;
                    state_nx = ST_DONE;
                end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ram or posedge init) begin
        if (init)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk_ram or posedge init) begin
        if (init) begin
            cnt      <= '0;
            fair     <= '0;
            own      <= OWN_NONE;
            wr       <= 1'b0;
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            cp_ack   <= 1'b0;
            rdata    <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wtbt <= 2'b11;
            ram_we   <= 1'b0;
            ram_rd   <= 1'b0;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            cp_ack  <= 1'b0;
            cnt     <= (state_nx != state || state == ST_IDLE) ? '0 : cnt + 5'd1;
            if (grant) begin
                own      <= winner;
                wr       <= sel_we;
                ram_addr <= sel_addr;
                ram_din  <= sel_din;
                ram_wtbt <= sel_wtbt;
                ram_we   <= sel_we;
                ram_rd   <= !sel_we;
            end
            if (slot_end) begin
                ram_we <= 1'b0;
                ram_rd <= 1'b0;
            end
            // ack and read data are registered so both are valid during DONE
            if (gap_end) begin
                vid_ack <= (own == OWN_VID);
                cpu_ack <= (own == OWN_CPU);
                cp_ack  <= (own == OWN_COPY);
                if (!wr)
                    rdata <= ram_dout;
            end
            if (state == ST_DONE)
                own <= OWN_NONE;
            if (!cp_req)
                fair <= '0;
            else if (grant && winner == OWN_COPY)
                fair <= '0;
            else if (grant && winner == OWN_CPU && fair != FAIR_MAX)
                fair <= fair + 1'b1;
        end
    end

    assign owner = own;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter.
// Outputs are sampled on the falling edge of clk_ram.
module tb_sram_arbiter;

    localparam int AW   = 24;
    localparam int SLOT = 24;
    localparam int GAP  = 3;
    localparam int LAT  = 1 + SLOT + GAP + 1;

    logic          clk_ram = 1'b0;
    logic          init;
    logic          vid_req, cpu_req, cpu_we, cp_req, cp_we;
    logic [AW-1:0] vid_addr, cpu_addr, cp_addr;
    logic [15:0]   cpu_din, cp_din, ram_dout;
    logic [1:0]    cpu_sel;
    logic          vid_ack, cpu_ack, cp_ack;
    logic [15:0]   rdata, ram_din;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_wtbt, owner;
    logic          ram_we, ram_rd;

    int n_checks = 0;
    int n_fail   = 0;

    sram_arbiter #(.AW(AW), .SLOT_CYC(SLOT), .GAP_CYC(GAP), .CPU_MAX(4)) dut (
        .clk_ram  (clk_ram),
        .init     (init),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_sel  (cpu_sel),
        .cp_req   (cp_req),
        .cp_we    (cp_we),
        .cp_addr  (cp_addr),
        .cp_din   (cp_din),
        .vid_ack  (vid_ack),
        .cpu_ack  (cpu_ack),
        .cp_ack   (cp_ack),
        .rdata    (rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_wtbt (ram_wtbt),
        .ram_we   (ram_we),
        .ram_rd   (ram_rd),
        .ram_dout (ram_dout),
        .owner    (owner)
    );

    always #5 clk_ram = ~clk_ram;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("assertion %s", tag);
        end
    endtask

    function automatic logic [2:0] ack_of(input logic [1:0] o);
        case (o)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Waits for the next grant, then follows the slot to its ack.
    // waits: falling edges from call to the grant sample (inclusive).
    // edges: falling edges from the grant sample to the ack sample.
    task automatic serve(input logic [1:0] exp_own, input string tag,
                         output int rd_hi, output int we_hi, output int lo,
                         output int waits, output int edges);
        rd_hi = 0;
        we_hi = 0;
        lo    = 0;
        edges = 0;
        waits = 1;
        @(negedge clk_ram);
        while (owner == 2'd0 && waits < 6) begin
            @(negedge clk_ram);
            waits++;
        end
        check({tag, "_owner"}, owner, exp_own);
        for (int i = 0; i < 100; i++) begin
            if (ram_rd) rd_hi++;
            if (ram_we) we_hi++;
            if (!ram_rd && !ram_we) lo++;
            if (vid_ack || cpu_ack || cp_ack) break;
            @(negedge clk_ram);
            edges++;
        end
        check({tag, "_ack"}, {vid_ack, cpu_ack, cp_ack}, ack_of(exp_own));
        check({tag, "_latency"}, edges + 2, LAT);
        check({tag, "_slot"}, rd_hi + we_hi, SLOT);
    endtask

    int rd_hi, we_hi, lo, waits, edges, acks, lo1;

    initial begin
        init = 1'b1;
        {vid_req, cpu_req, cpu_we, cp_req, cp_we} = '0;
        vid_addr = '0; cpu_addr = '0; cp_addr = '0;
        cpu_din = '0; cp_din = '0; cpu_sel = 2'b11; ram_dout = '0;

        @(negedge clk_ram);
        check("rst_rd", ram_rd, 1'b0);
        check("rst_we", ram_we, 1'b0);
        check("rst_acks", {vid_ack, cpu_ack, cp_ack}, 3'b000);
        check("rst_owner", owner, 2'd0);
        check("rst_rdata", rdata, 16'h0);
        check("rst_addr", ram_addr, 24'h0);
        check("rst_din", ram_din, 16'h0);
        check("rst_wtbt", ram_wtbt, 2'b11);
        init = 1'b0;

        // single cpu read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000100;
        ram_dout = 16'hA5A5;
        serve(2'd2, "cpu_rd", rd_hi, we_hi, lo, waits, edges);
        check("cpu_rd_rdhi", rd_hi, SLOT);
        check("cpu_rd_wehi", we_hi, 0);
        check("cpu_rd_rdata", rdata, 16'hA5A5);
        check("cpu_rd_addr", ram_addr, 24'h000100);
        cpu_req = 1'b0;
        @(negedge clk_ram);
        check("cpu_rd_ack_pulse", cpu_ack, 1'b0);
        check("cpu_rd_owner_clr", owner, 2'd0);

        // cpu byte write, high byte only
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h000200;
        cpu_sel = 2'b10; cpu_din = 16'h1234; ram_dout = 16'h7777;
        serve(2'd2, "cpu_wr", rd_hi, we_hi, lo, waits, edges);
        check("cpu_wr_wehi", we_hi, SLOT);
        check("cpu_wr_rdhi", rd_hi, 0);
        check("cpu_wr_wtbt", ram_wtbt, 2'b10);
        check("cpu_wr_din", ram_din, 16'h1234);
        check("cpu_wr_rdata_held", rdata, 16'hA5A5);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel = 2'b11;
        repeat (3) @(negedge clk_ram);

        // all three at once: vid, cpu, copy
        vid_req = 1'b1; vid_addr = 24'h000010;
        cpu_req = 1'b1; cpu_addr = 24'h000020;
        cp_req = 1'b1; cp_we = 1'b1; cp_addr = 24'h000300; cp_din = 16'hBEEF;
        ram_dout = 16'h1111;
        serve(2'd1, "tri_vid", rd_hi, we_hi, lo, waits, edges);
        check("tri_vid_addr", ram_addr, 24'h000010);
        check("tri_vid_rdata", rdata, 16'h1111);
        vid_req = 1'b0;
        ram_dout = 16'h2222;
        serve(2'd2, "tri_cpu", rd_hi, we_hi, lo, waits, edges);
        check("tri_cpu_rdata", rdata, 16'h2222);
        cpu_req = 1'b0;
        serve(2'd3, "tri_cp", rd_hi, we_hi, lo, waits, edges);
        check("tri_cp_wehi", we_hi, SLOT);
        check("tri_cp_din", ram_din, 16'hBEEF);
        check("tri_cp_wtbt", ram_wtbt, 2'b11);
        check("tri_cp_rdata_held", rdata, 16'h2222);
        cp_req = 1'b0;
        repeat (3) @(negedge clk_ram);

        // cpu held high while copy waits: four cpu slots, then copy
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000500;
        cp_req = 1'b1; cp_we = 1'b1; cp_addr = 24'h000600; cp_din = 16'hCAFE;
        for (int k = 0; k < 4; k++)
            serve(2'd2, $sformatf("fair_cpu%0d", k), rd_hi, we_hi, lo, waits, edges);
        serve(2'd3, "fair_cp", rd_hi, we_hi, lo, waits, edges);
        check("fair_cp_din", ram_din, 16'hCAFE);
        serve(2'd2, "fair_reset", rd_hi, we_hi, lo, waits, edges);
        cpu_req = 1'b0; cp_req = 1'b0;
        repeat (3) @(negedge clk_ram);

        // back-to-back reads of the same address
        cpu_req = 1'b1; cpu_addr = 24'h000700; ram_dout = 16'h5A5A;
        serve(2'd2, "b2b_first", rd_hi, we_hi, lo, waits, edges);
        check("b2b_first_rdata", rdata, 16'h5A5A);
        lo1 = lo;
        serve(2'd2, "b2b_second", rd_hi, we_hi, lo, waits, edges);
        check("b2b_second_rdata", rdata, 16'h5A5A);
        check("b2b_period", waits + edges, 1 + 1 + SLOT + GAP);
        check("b2b_gap_min", (lo1 + waits - 1) >= GAP, 1'b1);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk_ram);

        // reset in the middle of a read slot
        cpu_req = 1'b1; cpu_addr = 24'h000800; ram_dout = 16'h3C3C;
        @(negedge clk_ram);
        check("rst_mid_rd_on", ram_rd, 1'b1);
        repeat (5) @(negedge clk_ram);
        #2 init = 1'b1;
        #1;
        check("rst_mid_rd_off", ram_rd, 1'b0);
        check("rst_mid_owner", owner, 2'd0);
        cpu_req = 1'b0;
        @(negedge clk_ram);
        init = 1'b0;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_ram);
            if (vid_ack || cpu_ack || cp_ack) acks++;
        end
        check("rst_mid_no_ack", acks, 0);
        check("rst_mid_rdata", rdata, 16'h0);
        vid_req = 1'b1; vid_addr = 24'h000900; ram_dout = 16'h0F0F;
        serve(2'd1, "post_rst_vid", rd_hi, we_hi, lo, waits, edges);
        check("post_rst_rdata", rdata, 16'h0F0F);
        vid_req = 1'b0;
        repeat (2) @(negedge clk_ram);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
